// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: takes the PC on a fetch strobe, performs a word read
// over a req/ready handshake and latches the result into the instruction register.
// Decoded IR fields are combinational slices of the IR.
// Optional macro FETCH_TIMEOUT_EN: abandon a fetch after TIMEOUT_CYCLES wait
// cycles without mem_ready and pulse timeout_err.
module ins_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_IR       = 32'h00000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [5:0]  opcode,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  rd_idx,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immd16,
    output logic [25:0] immd26
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The wait counter is 8 bits wide, so the timeout must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        busy_q, busy_d;
    logic        misalign_q, misalign_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Next-state logic for the IDLE -> REQ -> DONE fetch sequence.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        misalign_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // mem_ready is deliberately ignored here.
                if (fetch_start) begin
                    if (pc[1:0] == 2'b00) begin
                        mem_addr_d = pc;
                        mem_req_d  = 1'b1;
                        state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_d = 8'd0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    ir_d       = mem_rdata;
                    mem_req_d  = 1'b0;
                    ir_valid_d = 1'b1;
                    state_d    = DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    mem_req_d  = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset; reset abandons any fetch in flight.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            ir_q       <= RESET_IR;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign busy         = busy_q;
    assign misalign_err = misalign_q;

    // Field slices only; sign extension is left to the consumer.
    assign opcode = ir_q[31:26];
    assign rs_idx = ir_q[25:21];
    assign rt_idx = ir_q[20:16];
    assign rd_idx = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign immd16 = ir_q[15:0];
    assign immd26 = ir_q[25:0];

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: directed cases followed by randomized
// fetch transactions checked against a transaction-level model of the fetch rules.
module tb_ins_fetch_unit;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] RIR = 32'h00000000;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] pc;
    logic        fetch_start;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        misalign_err;
    logic        timeout_err;
    logic [5:0]  opcode;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immd16;
    logic [25:0] immd26;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_ir;

    always #5 clk = ~clk;

    ins_fetch_unit #(
        .TIMEOUT_CYCLES(TO),
        .RESET_IR      (RIR)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .pc          (pc),
        .fetch_start (fetch_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .misalign_err(misalign_err),
        .timeout_err (timeout_err),
        .opcode      (opcode),
        .rs_idx      (rs_idx),
        .rt_idx      (rt_idx),
        .rd_idx      (rd_idx),
        .shamt       (shamt),
        .funct       (funct),
        .immd16      (immd16),
        .immd26      (immd26)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input logic [31:0] w);
        check_eq("opcode", 32'(opcode), w >> 26);
        check_eq("rs_idx", 32'(rs_idx), (w >> 21) & 32'h1f);
        check_eq("rt_idx", 32'(rt_idx), (w >> 16) & 32'h1f);
        check_eq("rd_idx", 32'(rd_idx), (w >> 11) & 32'h1f);
        check_eq("shamt", 32'(shamt), (w >> 6) & 32'h1f);
        check_eq("funct", 32'(funct), w & 32'h3f);
        check_eq("immd16", 32'(immd16), w & 32'hffff);
        check_eq("immd26", 32'(immd26), w & 32'h03ff_ffff);
    endtask

    // One fetch transaction: strobe at addr, memory answers after 'delay' wait
    // cycles with 'data'. With noise, pc/fetch_start/mem_ready are disturbed
    // wherever the unit must ignore them.
    task automatic fetch(input logic [31:0] addr, input int delay, input logic [31:0] data,
                         input bit noise);
        pc          = addr;
        fetch_start = 1'b1;
        mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata   = $urandom;
        step();
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        if (addr[1:0] != 2'b00) begin
            check_eq("misalign_pulse", 32'(misalign_err), 32'd1);
            check_eq("misalign_no_req", 32'(mem_req), 32'd0);
            check_eq("misalign_busy", 32'(busy), 32'd0);
            check_eq("misalign_ir", ir, exp_ir);
            step();
            check_eq("misalign_clear", 32'(misalign_err), 32'd0);
            check_eq("misalign_idle", 32'(busy), 32'd0);
            return;
        end
        check_eq("req_high", 32'(mem_req), 32'd1);
        check_eq("req_addr", mem_addr, addr);
        check_eq("req_busy", 32'(busy), 32'd1);
        check_eq("req_no_valid", 32'(ir_valid), 32'd0);
        for (int w = 0; w < delay; w++) begin
            if (noise) begin
                pc          = $urandom;
                fetch_start = 1'($urandom_range(0, 1));
            end
            mem_rdata = $urandom;
            step();
            fetch_start = 1'b0;
            if (TO_EN && (w + 1 == TO)) begin
                check_eq("timeout_pulse", 32'(timeout_err), 32'd1);
                check_eq("timeout_req", 32'(mem_req), 32'd0);
                check_eq("timeout_busy", 32'(busy), 32'd0);
                check_eq("timeout_ir", ir, exp_ir);
                step();
                check_eq("timeout_clear", 32'(timeout_err), 32'd0);
                return;
            end
            check_eq("wait_req", 32'(mem_req), 32'd1);
            check_eq("wait_addr", mem_addr, addr);
            check_eq("wait_no_valid", 32'(ir_valid), 32'd0);
            check_eq("wait_ir", ir, exp_ir);
            check_eq("wait_no_timeout", 32'(timeout_err), 32'd0);
        end
        mem_ready   = 1'b1;
        mem_rdata   = data;
        fetch_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        mem_ready   = 1'b0;
        fetch_start = noise;
        exp_ir      = data;
        check_eq("done_valid", 32'(ir_valid), 32'd1);
        check_eq("done_ir", ir, exp_ir);
        check_eq("done_req", 32'(mem_req), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd1);
        check_eq("done_timeout", 32'(timeout_err), 32'd0);
        check_fields(exp_ir);
        step();
        fetch_start = 1'b0;
        check_eq("after_valid", 32'(ir_valid), 32'd0);
        check_eq("after_busy", 32'(busy), 32'd0);
        check_eq("after_req", 32'(mem_req), 32'd0);
        check_eq("after_ir", ir, exp_ir);
    endtask

    initial begin
        RST         = 1'b1;
        pc          = 32'h0;
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        exp_ir      = RIR;
        step();
        step();
        RST = 1'b0;
        check_eq("rst_ir", ir, RIR);
        check_eq("rst_valid", 32'(ir_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_misalign", 32'(misalign_err), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        step();
        check_eq("idle_req", 32'(mem_req), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Directed: immediate ready, then the known lw encoding.
        fetch(32'h0000_0040, 0, 32'h8C22_0004, 1'b0);
        check_eq("lw_opcode", 32'(opcode), 32'h23);
        check_eq("lw_rs", 32'(rs_idx), 32'd1);
        check_eq("lw_rt", 32'(rt_idx), 32'd2);
        check_eq("lw_immd16", 32'(immd16), 32'h0004);

        // Five wait cycles with pc moving and a second strobe during the wait.
        fetch(32'h0000_0040, 5, 32'h2001_ABCD, 1'b1);

        // Misaligned strobe.
        fetch(32'h0000_0042, 0, 32'hDEAD_BEEF, 1'b0);

        // Memory silent for 100 cycles: times out if enabled, otherwise waits.
        fetch(32'h0000_0080, 100, 32'h1234_5678, 1'b0);

        // Reset in the middle of a request.
        pc          = 32'h0000_0200;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_ir = RIR;
        check_eq("midrst_req", 32'(mem_req), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ir", ir, RIR);
        check_eq("midrst_valid", 32'(ir_valid), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ready = 1'b0;
        check_eq("late_ready_ir", ir, RIR);
        check_eq("late_ready_valid", 32'(ir_valid), 32'd0);
        check_eq("late_ready_busy", 32'(busy), 32'd0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int          d;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 12)) : int'($urandom_range(0, 3));
            fetch(a, d, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
